// File: rtl/exe_hazard_ctrl.sv
// EX-stage hazard sequencer: tracks the EX/MEM/WB destinations, drives the
// EX forwarding selects, and generates load-use bubbles, branch flushes and
// the SRAM-wait freeze for the surrounding pipeline.
module exe_hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_st,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic [1:0]       val1_sel,
  output logic [1:0]       val2_sel,
  output logic [1:0]       st_val_sel,
  output logic             hold_pc,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic             st;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
    logic             mem_write;
  } slot_t;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_MEMWAIT = 2'd1, S_FLUSH = 2'd2} state_t;

  slot_t            r_ex, r_mem, r_wb;
  slot_t            w_id_slot;
  state_t           r_state, w_state_nxt;
  logic             w_mem_stall, w_src2_live, w_hazard, w_br_flush;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // A slot produces register r when it is live, writes back, and r is not r0.
  function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.wb_en && (s.dest != '0) && (s.dest == r);
  endfunction

  // MEM result is newer than WB, so it wins when both produce r.
  function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                         input logic [REG_W-1:0] r);
    if (!FWD_EN)           return 2'b00;
    if (writes_reg(m, r))  return 2'b01;
    if (writes_reg(w, r))  return 2'b10;
    return 2'b00;
  endfunction

  // ID reads a producer's dest through src1 always, through src2 when it is an operand or store data.
  function automatic logic id_reads(input slot_t s, input logic [REG_W-1:0] s1,
                                    input logic [REG_W-1:0] s2, input logic live2);
    return writes_reg(s, s1) || (live2 && writes_reg(s, s2));
  endfunction

  assign w_id_slot = '{valid: 1'b1, src1: id_src1, src2: id_src2, two_src: id_two_src,
                       st: id_st, dest: id_dest, wb_en: id_wb_en,
                       mem_read: id_mem_read, mem_write: id_mem_write};

  assign w_src2_live = id_two_src | id_st;
  assign w_mem_stall = r_mem.valid & (r_mem.mem_read | r_mem.mem_write) & ~mem_ready;

  // Without forwarding every RAW on an EX or MEM producer must wait; with it only a load in EX does.
  assign w_hazard = FWD_EN
    ? (r_ex.valid & r_ex.mem_read & (r_ex.dest != '0) &
       ((id_src1 == r_ex.dest) | (w_src2_live & (id_src2 == r_ex.dest))))
    : (id_reads(r_ex, id_src1, id_src2, w_src2_live) |
       id_reads(r_mem, id_src1, id_src2, w_src2_live));

  assign val1_sel   = r_ex.valid ? fwd_sel(r_mem, r_wb, r_ex.src1) : 2'b00;
  assign val2_sel   = (r_ex.valid & r_ex.two_src) ? fwd_sel(r_mem, r_wb, r_ex.src2) : 2'b00;
  assign st_val_sel = (r_ex.valid & r_ex.st) ? fwd_sel(r_mem, r_wb, r_ex.src2) : 2'b00;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: freeze beats flush; a branch during the wait is taken once memory is ready.
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch behind.
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:     if (w_mem_stall)  w_state_nxt = S_MEMWAIT;
                 else if (br_taken) w_state_nxt = S_FLUSH;
      S_MEMWAIT: if (mem_ready)    w_state_nxt = br_taken ? S_FLUSH : S_RUN;
      S_FLUSH:   if (!w_mem_stall) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  // Pipeline controls with priority freeze > flush > load-use.
  always_comb begin
    hold_pc     = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    freeze      = 1'b0;
    w_br_flush  = 1'b0;
    unique case (r_state)
      S_FLUSH: begin
        if (w_mem_stall) begin
          freeze  = 1'b1;
          hold_pc = 1'b1;
        end else begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      default: begin
        // MEM is held while waiting, so the wait ends exactly when mem_ready rises.
        if ((r_state == S_MEMWAIT) ? ~mem_ready : w_mem_stall) begin
          freeze  = 1'b1;
          hold_pc = 1'b1;
        end else if (br_taken) begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
          w_br_flush  = 1'b1;
        end else if (w_hazard) begin
          hold_pc   = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    endcase
  end

  // Shadow slots advance with the datapath unless frozen; bubbles enter EX as all-zero slots.
  always_ff @(posedge clk) begin
    // NOTE: slots are cleared on reset because forwarding and stalls read their valid bits.
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (bubble_ex | flush_if_id) ? '0 : w_id_slot;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((hold_pc | freeze) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_br_flush && (r_flush_cnt != '1))         r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed cycle table for the listed scenarios,
// then random traffic against a queue-based pipeline model. A second
// instance with 4-bit counters exposes saturation.
module tb_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, id_dest;
  logic       id_two_src, id_st, id_wb_en, id_mem_read, id_mem_write;
  logic       br_taken, mem_ready;

  logic [1:0]  val1_sel, val2_sel, st_val_sel;
  logic        hold_pc, bubble_ex, flush_if_id, freeze;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_val1_sel, s_val2_sel, s_st_val_sel;
  logic        s_hold_pc, s_bubble_ex, s_flush_if_id, s_freeze;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  exe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_st(id_st), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .br_taken(br_taken), .mem_ready(mem_ready),
    .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel), .hold_pc(hold_pc),
    .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .freeze(freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  exe_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_st(id_st), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .br_taken(br_taken), .mem_ready(mem_ready),
    .val1_sel(s_val1_sel), .val2_sel(s_val2_sel), .st_val_sel(s_st_val_sel),
    .hold_pc(s_hold_pc), .bubble_ex(s_bubble_ex), .flush_if_id(s_flush_if_id),
    .freeze(s_freeze), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] s1, s2, d;
    logic       two, st, wb, mr, mw;
  } ins_t;

  // {val1_sel, val2_sel, st_val_sel, hold_pc, bubble_ex, flush_if_id, freeze}
  typedef struct packed {
    logic [1:0] v1, v2, sv;
    logic       h, b, f, z;
  } ctl_t;

  typedef struct {
    ins_t id;
    bit   br, rdy, rs;
    ctl_t exp;
    int   sc, fc;
  } vec_t;

  typedef struct packed {
    logic v;
    ins_t i;
  } mslot_t;

  localparam logic [3:0] C0 = 4'b0000, C_LU = 4'b1100, C_FL = 4'b0110, C_FZ = 4'b1001;

  int n_checks = 0;
  int n_errors = 0;

  vec_t   tbl[$];
  mslot_t pipe[$];   // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  bit     m_pend;
  int     m_stall, m_flush;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t alu(logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
    ins_t i = '0;
    i.d = d; i.s1 = s1; i.s2 = s2; i.two = 1'b1; i.wb = 1'b1;
    return i;
  endfunction
  function automatic ins_t alu1(logic [4:0] d, logic [4:0] s1);
    ins_t i = '0;
    i.d = d; i.s1 = s1; i.wb = 1'b1;
    return i;
  endfunction
  function automatic ins_t lw(logic [4:0] d, logic [4:0] base);
    ins_t i = '0;
    i.d = d; i.s1 = base; i.wb = 1'b1; i.mr = 1'b1;
    return i;
  endfunction
  function automatic ins_t sw(logic [4:0] base, logic [4:0] data);
    ins_t i = '0;
    i.s1 = base; i.s2 = data; i.st = 1'b1; i.mw = 1'b1;
    return i;
  endfunction

  function automatic vec_t mk(ins_t id, bit br, bit rdy, bit rs, logic [1:0] v1,
                              logic [1:0] v2, logic [1:0] sv, logic [3:0] ctl, int sc, int fc);
    vec_t v;
    v.id = id; v.br = br; v.rdy = rdy; v.rs = rs;
    v.exp = {v1, v2, sv, ctl};
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic apply(ins_t id, bit br, bit rdy, bit rs);
    id_src1 = id.s1; id_src2 = id.s2; id_dest = id.d;
    id_two_src = id.two; id_st = id.st; id_wb_en = id.wb;
    id_mem_read = id.mr; id_mem_write = id.mw;
    br_taken = br; mem_ready = rdy; rst = rs;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    return {val1_sel, val2_sel, st_val_sel, hold_pc, bubble_ex, flush_if_id, freeze};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit writes(mslot_t s, logic [4:0] r);
    return s.v && s.i.wb && (s.i.d != 5'd0) && (s.i.d == r);
  endfunction

  function automatic logic [1:0] src_sel(logic [4:0] r);
    if (writes(pipe[1], r)) return 2'd1;
    if (writes(pipe[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    mslot_t e = '0;
    pipe = {e, e, e};
    m_pend = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  function automatic ctl_t model_eval(ins_t id, bit br, bit rdy);
    ctl_t   e;
    mslot_t ex;
    bit     busy, lu;
    e  = '0;
    ex = pipe[0];
    busy = pipe[1].v && (pipe[1].i.mr || pipe[1].i.mw);
    if (ex.v) begin
      e.v1 = src_sel(ex.i.s1);
      if (ex.i.two) e.v2 = src_sel(ex.i.s2);
      if (ex.i.st)  e.sv = src_sel(ex.i.s2);
    end
    lu = ex.v && ex.i.mr && (ex.i.d != 5'd0) &&
         ((id.s1 == ex.i.d) || ((id.two || id.st) && (id.s2 == ex.i.d)));
    if (busy && !rdy)      begin e.z = 1'b1; e.h = 1'b1; end
    else if (m_pend || br) begin e.f = 1'b1; e.b = 1'b1; end
    else if (lu)           begin e.h = 1'b1; e.b = 1'b1; end
    return e;
  endfunction

  task automatic model_step(ins_t id, bit br, bit rs, ctl_t e);
    mslot_t ns;
    if (rs) begin
      model_reset();
    end else begin
      if (e.h || e.z) m_stall++;
      if (!e.z && !m_pend && br) m_flush++;
      if (!e.z) begin
        ns = (e.b || e.f) ? '0 : {1'b1, id};
        void'(pipe.pop_back());
        pipe.push_front(ns);
        m_pend = !m_pend && br;
      end
    end
  endtask

  function automatic ins_t rand_ins();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0:       return nop();
      1:       return alu(a, b, c);
      2:       return alu1(a, b);
      3:       return lw(a, b);
      default: return sw(b, c);
    endcase
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    ins_t cur;
    ctl_t e;
    bit   br, rdy, rs, keep;

    // Directed scenarios, one row per cycle: inputs then expected outputs.
    tbl.push_back(mk(alu(3,1,2),  0,1,0, 0,0,0, C0,   0,0));  // 0
    tbl.push_back(mk(alu(4,3,3),  0,1,0, 0,0,0, C0,   0,0));  // 1
    tbl.push_back(mk(nop(),       0,1,0, 1,1,0, C0,   0,0));  // 2 ADD r4 forwards r3 from MEM twice
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   0,0));  // 3
    tbl.push_back(mk(alu(3,1,2),  0,1,0, 0,0,0, C0,   0,0));  // 4
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   0,0));  // 5
    tbl.push_back(mk(alu(5,3,1),  0,1,0, 0,0,0, C0,   0,0));  // 6
    tbl.push_back(mk(nop(),       0,1,0, 2,0,0, C0,   0,0));  // 7 SUB takes r3 from WB
    tbl.push_back(mk(lw(2,7),     0,1,0, 0,0,0, C0,   0,0));  // 8
    tbl.push_back(mk(alu(6,2,1),  0,1,0, 0,0,0, C_LU, 0,0));  // 9 load-use
    tbl.push_back(mk(alu(6,2,1),  0,1,0, 0,0,0, C0,   1,0));  // 10
    tbl.push_back(mk(nop(),       0,1,0, 2,0,0, C0,   1,0));  // 11
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   1,0));  // 12
    tbl.push_back(mk(alu(7,1,1),  1,1,0, 0,0,0, C_FL, 1,0));  // 13 branch taken
    tbl.push_back(mk(alu(8,1,1),  0,1,0, 0,0,0, C_FL, 1,1));  // 14 second bubble
    tbl.push_back(mk(alu(12,1,2), 0,1,0, 0,0,0, C0,   1,1));  // 15
    tbl.push_back(mk(lw(9,1),     0,1,0, 0,0,0, C0,   1,1));  // 16
    tbl.push_back(mk(alu1(13,12), 0,1,0, 0,0,0, C0,   1,1));  // 17
    tbl.push_back(mk(nop(),       0,0,0, 2,0,0, C_FZ, 1,1));  // 18 SRAM wait 1
    tbl.push_back(mk(nop(),       1,0,0, 2,0,0, C_FZ, 2,1));  // 19 wait 2, branch ignored
    tbl.push_back(mk(nop(),       0,0,0, 2,0,0, C_FZ, 3,1));  // 20 wait 3
    tbl.push_back(mk(nop(),       0,1,0, 2,0,0, C0,   4,1));  // 21 released, EX unchanged
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   4,1));  // 22
    tbl.push_back(mk(alu(0,1,2),  0,1,0, 0,0,0, C0,   4,1));  // 23 r0 producer
    tbl.push_back(mk(alu(14,0,0), 0,1,0, 0,0,0, C0,   4,1));  // 24
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   4,1));  // 25 r0 never forwards
    tbl.push_back(mk(lw(0,1),     0,1,0, 0,0,0, C0,   4,1));  // 26
    tbl.push_back(mk(alu(15,0,1), 0,1,0, 0,0,0, C0,   4,1));  // 27 load to r0: no stall
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   4,1));  // 28
    tbl.push_back(mk(alu(5,1,2),  0,1,0, 0,0,0, C0,   4,1));  // 29
    tbl.push_back(mk(sw(6,5),     0,1,0, 0,0,0, C0,   4,1));  // 30
    tbl.push_back(mk(nop(),       0,1,0, 0,0,1, C0,   4,1));  // 31 store data from MEM
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   4,1));  // 32
    tbl.push_back(mk(lw(4,1),     0,1,0, 0,0,0, C0,   4,1));  // 33
    tbl.push_back(mk(sw(1,4),     0,1,0, 0,0,0, C_LU, 4,1));  // 34 store data is a live source
    tbl.push_back(mk(sw(1,4),     0,1,0, 0,0,0, C0,   5,1));  // 35
    tbl.push_back(mk(nop(),       0,1,0, 0,0,2, C0,   5,1));  // 36 store data from WB
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   5,1));  // 37
    tbl.push_back(mk(lw(2,1),     0,1,0, 0,0,0, C0,   5,1));  // 38
    tbl.push_back(mk(nop(),       0,1,0, 0,0,0, C0,   5,1));  // 39
    tbl.push_back(mk(nop(),       0,0,0, 0,0,0, C_FZ, 5,1));  // 40 freeze
    tbl.push_back(mk(nop(),       0,0,1, 0,0,0, C_FZ, 6,1));  // 41 reset mid-freeze
    tbl.push_back(mk(nop(),       0,0,0, 0,0,0, C0,   0,0));  // 42 all clear after reset

    apply(nop(), 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 apply(nop(), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("reset ctl",        32'(dut_ctl()), 32'd0);
    check("reset stall_cnt",  32'(stall_cnt), 32'd0);
    check("reset flush_cnt",  32'(flush_cnt), 32'd0);
    check("reset s_stall",    32'(s_stall_cnt), 32'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      apply(tbl[i].id, tbl[i].br, tbl[i].rdy, tbl[i].rs);
      @(negedge clk);
      check($sformatf("row%0d ctl", i),       32'(dut_ctl()),  32'(tbl[i].exp));
      check($sformatf("row%0d stall_cnt", i), 32'(stall_cnt),  32'(tbl[i].sc));
      check($sformatf("row%0d flush_cnt", i), 32'(flush_cnt),  32'(tbl[i].fc));
      @(posedge clk); #1;
    end

    // Random traffic against the model; ID stays put while the model says PC is held.
    apply(nop(), 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    model_reset();
    cur  = nop();
    keep = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!keep) cur = rand_ins();
      br  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 255) == 0);
      apply(cur, br, rdy, rs);
      e = model_eval(cur, br, rdy);
      @(negedge clk);
      check($sformatf("rand%0d ctl", n),       32'(dut_ctl()),   32'(e));
      check($sformatf("rand%0d stall_cnt", n), 32'(stall_cnt),   32'(sat(m_stall, 65535)));
      check($sformatf("rand%0d flush_cnt", n), 32'(flush_cnt),   32'(sat(m_flush, 65535)));
      check($sformatf("rand%0d sat_stall", n), 32'(s_stall_cnt), 32'(sat(m_stall, 15)));
      check($sformatf("rand%0d sat_flush", n), 32'(s_flush_cnt), 32'(sat(m_flush, 15)));
      @(posedge clk); #1;
      model_step(cur, br, rs, e);
      keep = e.h && !rs;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
